// File: rtl/maquina_receptor.sv
// Snoop-side MSI controller: owns the line state/tag table of one private cache,
// reacts to bus coherence messages and drives the write-back handshake on Modified hits.
module maquina_receptor #(
   parameter int NUM_LINHAS = 4,
   parameter int TAG_W      = 4,
   parameter int IDX_W      = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             msg_valida,
   input  logic [1:0]       msg,
   input  logic [TAG_W-1:0] msg_tag,
   output logic             msg_aceita,
   input  logic             local_escrita,
   input  logic [IDX_W-1:0] local_linha,
   input  logic [TAG_W-1:0] local_tag,
   input  logic [1:0]       local_estado,
   input  logic [IDX_W-1:0] consulta_linha,
   output logic [1:0]       consulta_estado,
   output logic [TAG_W-1:0] consulta_tag,
   output logic             wb_req,
   output logic [IDX_W-1:0] wb_linha,
   input  logic             wb_ack,
   output logic             abortar_mem,
   output logic             ocupado,
   output logic             erro_protocolo
);

   localparam logic [1:0] INVALIDO      = 2'b00;
   localparam logic [1:0] MODIFICADO    = 2'b01;
   localparam logic [1:0] COMPARTILHADO = 2'b10;

   localparam logic [1:0] INVALIDAR     = 2'b00;
   localparam logic [1:0] READ_MISS     = 2'b01;
   localparam logic [1:0] WRITE_MISS    = 2'b10;
   localparam logic [1:0] SEM_MENSAGEM  = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO,
      BUSCA,
      WRITEBACK
   } estado_fsm_t;

   estado_fsm_t estado_q, estado_d;

   logic [1:0]       tab_estado [NUM_LINHAS];
   logic [TAG_W-1:0] tab_tag    [NUM_LINHAS];

   logic [1:0]       msg_q;
   logic [TAG_W-1:0] tag_q;
   logic [1:0]       pendente_q, pendente_d;

   logic             aceita_d, wb_req_d, abortar_d, ocupado_d, erro_d;
   logic [IDX_W-1:0] wb_linha_d;

   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic [1:0]       hit_estado;

   logic             escreve_tab;
   logic [IDX_W-1:0] escreve_idx;
   logic [1:0]       escreve_estado;

   logic             transferencia;
   logic             escrita_local_ok;
   logic [1:0]       local_estado_ok;

   assign transferencia    = msg_valida && msg_aceita && (estado_q == OCIOSO);
   assign escrita_local_ok = local_escrita && (estado_q == OCIOSO);
   assign local_estado_ok  = (local_estado == 2'b11) ? INVALIDO : local_estado;

   assign consulta_estado = tab_estado[consulta_linha];
   assign consulta_tag    = tab_tag[consulta_linha];

   // Scanning downwards lets the lowest matching index win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_LINHAS - 1; i >= 0; i--) begin
         if ((tab_estado[i] != INVALIDO) && (tab_tag[i] == tag_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign hit_estado = tab_estado[hit_idx];

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      estado_d       = estado_q;
      pendente_d     = pendente_q;
      wb_req_d       = wb_req;
      wb_linha_d     = wb_linha;
      abortar_d      = 1'b0;
      erro_d         = erro_protocolo;
      escreve_tab    = 1'b0;
      escreve_idx    = hit_idx;
      escreve_estado = INVALIDO;

      case (estado_q)
         OCIOSO: begin
            if (transferencia && (msg != SEM_MENSAGEM)) begin
               estado_d = BUSCA;
            end
         end

         BUSCA: begin
            estado_d = OCIOSO;
            if (hit) begin
               if (hit_estado == COMPARTILHADO) begin
                  escreve_tab = (msg_q != READ_MISS);
               end else if (hit_estado == MODIFICADO) begin
                  if (msg_q == INVALIDAR) begin
                     erro_d      = 1'b1;
                     escreve_tab = 1'b1;
                  end else if ((msg_q == READ_MISS) || (msg_q == WRITE_MISS)) begin
                     estado_d   = WRITEBACK;
                     pendente_d = (msg_q == READ_MISS) ? COMPARTILHADO : INVALIDO;
                     wb_req_d   = 1'b1;
                     wb_linha_d = hit_idx;
                     abortar_d  = 1'b1;
                  end
               end
            end
         end

         WRITEBACK: begin
            if (wb_ack) begin
               escreve_tab    = 1'b1;
               escreve_idx    = wb_linha;
               escreve_estado = pendente_q;
               wb_req_d       = 1'b0;
               estado_d       = OCIOSO;
            end
         end

         default: begin
            estado_d = OCIOSO;
            wb_req_d = 1'b0;
         end
      endcase

      aceita_d  = (estado_d == OCIOSO);
      ocupado_d = (estado_d != OCIOSO);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q       <= OCIOSO;
         msg_q          <= SEM_MENSAGEM;
         tag_q          <= '0;
         pendente_q     <= INVALIDO;
         msg_aceita     <= 1'b1;
         wb_req         <= 1'b0;
         wb_linha       <= '0;
         abortar_mem    <= 1'b0;
         ocupado        <= 1'b0;
         erro_protocolo <= 1'b0;
      end else begin
         estado_q       <= estado_d;
         pendente_q     <= pendente_d;
         msg_aceita     <= aceita_d;
         wb_req         <= wb_req_d;
         wb_linha       <= wb_linha_d;
         abortar_mem    <= abortar_d;
         ocupado        <= ocupado_d;
         erro_protocolo <= erro_d;
         if (transferencia) begin
            msg_q <= msg;
            tag_q <= msg_tag;
         end
      end
   end

   // FSM updates and local writes never coincide: local writes only land in OCIOSO.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_LINHAS; i++) begin
            tab_estado[i] <= INVALIDO;
            tab_tag[i]    <= '0;
         end
      end else if (escreve_tab) begin
         tab_estado[escreve_idx] <= escreve_estado;
      end else if (escrita_local_ok) begin
         tab_estado[local_linha] <= local_estado_ok;
         tab_tag[local_linha]    <= local_tag;
      end
   end

endmodule
